// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit_pkg                                          |
// | Description : Shared definitions for the load/store unit: data width,      |
// |               memory size default, RV funct3 size/sign codes, FSM state    |
// |               encoding and a funct3 legality helper.                       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package load_store_unit_pkg;

  localparam int LSU_XLEN      = 64;
  localparam int LSU_MEM_BYTES = 2048;

  // Load funct3 codes; stores reuse the low two bits for size (SB=000 .. SD=011).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_e;

  // Stores have no unsigned variants, so any funct3[2]=1 store is illegal;
  // loads only lack a "LDU" (111).
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    return write ? funct3[2] : (funct3 == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit_align                                        |
// | Description : Combinational big-endian data alignment. Extracts and        |
// |               sign/zero-extends load data from the top of the memory word, |
// |               and merges store data into the old doubleword for RMW.       |
// | Ports       : i_funct3     - access size/sign                              |
// |               i_rdata      - memory read data (addressed byte in MSBs)     |
// |               i_old_data   - previously read doubleword for merging        |
// |               i_wdata      - store data, bytes taken from LSBs             |
// |               o_load_data  - extended load result                          |
// |               o_merge_data - doubleword to write back                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_old_data,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_merge_data
);

  // The addressed byte is always overwritten by any store, so the old top byte
  // never reaches the merged result.
  logic w_unused_old_top;
  assign w_unused_old_top = ^i_old_data[XLEN-1 -: 8];

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_LB:   o_load_data = {{(XLEN-8){i_rdata[XLEN-1]}},  i_rdata[XLEN-1 -: 8]};
      F3_LBU:  o_load_data = {{(XLEN-8){1'b0}},             i_rdata[XLEN-1 -: 8]};
      F3_LH:   o_load_data = {{(XLEN-16){i_rdata[XLEN-1]}}, i_rdata[XLEN-1 -: 16]};
      F3_LHU:  o_load_data = {{(XLEN-16){1'b0}},            i_rdata[XLEN-1 -: 16]};
      F3_LW:   o_load_data = {{(XLEN-32){i_rdata[XLEN-1]}}, i_rdata[XLEN-1 -: 32]};
      F3_LWU:  o_load_data = {{(XLEN-32){1'b0}},            i_rdata[XLEN-1 -: 32]};
      F3_LD:   o_load_data = i_rdata;
      default: o_load_data = '0;
    endcase
  end

  // Store data lands in the most significant bytes (lowest addresses);
  // the remaining low bytes keep the old memory contents.
  always_comb begin
    o_merge_data = i_wdata;
    case (i_funct3)
      F3_LB:   o_merge_data = {i_wdata[7:0],  i_old_data[XLEN-9:0]};
      F3_LH:   o_merge_data = {i_wdata[15:0], i_old_data[XLEN-17:0]};
      F3_LW:   o_merge_data = {i_wdata[31:0], i_old_data[XLEN-33:0]};
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : Core-side initiator for a byte-addressed big-endian 64-bit   |
// |               data memory (combinational read, synchronous write). Runs    |
// |               one RV64 load/store at a time: loads read once, SD writes    |
// |               once, SB/SH/SW read-modify-write; illegal funct3 or          |
// |               out-of-range address responds with an error, no access.      |
// | Ports       : clk, reset_n (sync active-low)                               |
// |               req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata  |
// |               resp_valid/resp_rdata/resp_err                               |
// |               mem_read/mem_write/mem_addr/mem_wdata/mem_rdata              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN      = LSU_XLEN,
  parameter int MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  // Highest legal start address: every access touches 8 bytes, and addresses
  // near the top are rejected rather than wrapped.
  localparam logic [XLEN-1:0] c_max_addr = XLEN'(MEM_BYTES - 8);

  lsu_state_e      r_state;
  lsu_state_e      w_state_next;

  logic            r_write;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_merge;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_err;

  logic            w_accept;
  logic            w_req_err;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merge_data;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = funct3_illegal(req_write, req_funct3) || (req_addr > c_max_addr);

  load_store_unit_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_funct3     (r_funct3),
    .i_rdata      (mem_rdata),
    .i_old_data   (r_merge),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and strobes
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err) begin
            w_state_next = S_RESP;
          end else if (!req_write) begin
            w_state_next = S_RD;
          end else if (req_funct3 == F3_LD) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        mem_read     = 1'b1;
        w_state_next = S_RESP;
      end
      S_RMW_RD: begin
        mem_read     = 1'b1;
        w_state_next = S_WR;
      end
      S_WR: begin
        mem_write    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, merge register and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write      <= req_write;
        r_funct3     <= req_funct3;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        // Stores and errors respond with zero data.
        r_resp_rdata <= '0;
        r_resp_err   <= w_req_err;
      end
      if (r_state == S_RD) begin
        r_resp_rdata <= w_load_data;
      end
      if (r_state == S_RMW_RD) begin
        r_merge <= mem_rdata;
      end
    end
  end

  // r_write only steers the FSM at accept time; kept for observability.
  logic w_unused_write;
  assign w_unused_write = r_write;

  assign mem_addr   = r_addr;
  assign mem_wdata  = mem_write ? w_merge_data : '0;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                           |
// | Description : Self-checking bench for load_store_unit with a big-endian    |
// |               byte memory model. Directed requests push expected responses |
// |               into a scoreboard; a monitor pops and compares each response.|
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  load_store_unit #(
    .XLEN      (64),
    .MEM_BYTES (2048)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [0:2047];
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;
  logic        seen_rd = 1'b0;
  logic        seen_wr = 1'b0;

  // Combinational big-endian read; out-of-range addresses read as zero.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'd2040) begin
      for (int i = 0; i < 8; i++) begin
        mem_rdata[63-8*i -: 8] = mem[mem_addr[10:0] + 11'(i)];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (!reset_n) begin
      seen_rd = 1'b0;
      seen_wr = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        chk("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
        if (sb.size() > 0) chk("mem_addr", mem_addr, sb[0].addr);
      end
      if (mem_read)  seen_rd = 1'b1;
      if (mem_write) seen_wr = 1'b1;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("saw_mem_read", 64'(seen_rd), 64'(e.rd));
          chk("saw_mem_write", 64'(seen_wr), 64'(e.wr));
        end
        seen_rd = 1'b0;
        seen_wr = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_rdata,
                       input logic exp_err, input int lat, input logic rd, input logic wr);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    e = '{rdata: exp_rdata, err: exp_err, lat: lat, rd: rd, wr: wr, addr: a, acc: cyc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("resp_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    logic [2:0]  pw_dummy;
    int          wc0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[7] = 8'h08;
    {mem[32], mem[33], mem[34], mem[35], mem[36], mem[37], mem[38], mem[39]} = 64'h8040201008040201;
    {mem[40], mem[41], mem[42], mem[43], mem[44], mem[45], mem[46], mem[47]} = 64'h80C0A09088848281;
    pw_dummy   = 3'b000;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = pw_dummy;
    req_addr   = '0;
    req_wdata  = '0;

    fork
      // Memory write port: capture the strobe mid-cycle, commit at the edge.
      begin : mem_proc
        logic        pw;
        logic [63:0] pa;
        logic [63:0] pd;
        forever begin
          @(negedge clk);
          pw = mem_write;
          pa = mem_addr;
          pd = mem_wdata;
          @(posedge clk);
          if (pw && pa <= 64'd2040) begin
            for (int i = 0; i < 8; i++) mem[pa[10:0] + 11'(i)] = pd[63-8*i -: 8];
            wr_count++;
          end
        end
      end
      begin : mon_proc
        forever begin
          @(negedge clk);
          monitor_step();
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    reset_n = 1'b1;

    //     wr    f3      addr     wdata                  expected rdata          err lat rd wr
    issue(1'b0, 3'b011, 64'd0,  64'h0,                 64'h0000000000000008, 1'b0, 2, 1'b1, 1'b0); // LD
    issue(1'b0, 3'b000, 64'd32, 64'h0,                 64'hFFFFFFFFFFFFFF80, 1'b0, 2, 1'b1, 1'b0); // LB
    issue(1'b0, 3'b100, 64'd32, 64'h0,                 64'h0000000000000080, 1'b0, 2, 1'b1, 1'b0); // LBU
    issue(1'b0, 3'b001, 64'd40, 64'h0,                 64'hFFFFFFFFFFFF80C0, 1'b0, 2, 1'b1, 1'b0); // LH
    issue(1'b0, 3'b110, 64'd40, 64'h0,                 64'h0000000080C0A090, 1'b0, 2, 1'b1, 1'b0); // LWU
    issue(1'b0, 3'b010, 64'd40, 64'h0,                 64'hFFFFFFFF80C0A090, 1'b0, 2, 1'b1, 1'b0); // LW
    issue(1'b0, 3'b101, 64'd32, 64'h0,                 64'h0000000000008040, 1'b0, 2, 1'b1, 1'b0); // LHU
    issue(1'b1, 3'b000, 64'd40, 64'hFFFFFFFFFFFFFF0C,  64'h0,                1'b0, 3, 1'b1, 1'b1); // SB
    issue(1'b0, 3'b011, 64'd40, 64'h0,                 64'h0CC0A09088848281, 1'b0, 2, 1'b1, 1'b0); // LD
    issue(1'b1, 3'b011, 64'd8,  64'h1122334455667788,  64'h0,                1'b0, 2, 1'b0, 1'b1); // SD
    issue(1'b0, 3'b011, 64'd8,  64'h0,                 64'h1122334455667788, 1'b0, 2, 1'b1, 1'b0); // LD
    issue(1'b1, 3'b001, 64'd32, 64'h000000000000ABCD,  64'h0,                1'b0, 3, 1'b1, 1'b1); // SH
    issue(1'b0, 3'b011, 64'd32, 64'h0,                 64'hABCD201008040201, 1'b0, 2, 1'b1, 1'b0); // LD
    issue(1'b0, 3'b001, 64'd36, 64'h0,                 64'h0000000000000804, 1'b0, 2, 1'b1, 1'b0); // LH positive
    issue(1'b1, 3'b010, 64'd0,  64'hCAFEBABE12345678,  64'h0,                1'b0, 3, 1'b1, 1'b1); // SW
    issue(1'b0, 3'b011, 64'd0,  64'h0,                 64'h1234567800000008, 1'b0, 2, 1'b1, 1'b0); // LD
    issue(1'b0, 3'b011, 64'd1,  64'h0,                 64'h3456780000000811, 1'b0, 2, 1'b1, 1'b0); // LD unaligned
    issue(1'b0, 3'b011, 64'd2040, 64'h0,               64'h0,                1'b0, 2, 1'b1, 1'b0); // LD top legal
    issue(1'b0, 3'b011, 64'd2041, 64'h0,               64'h0,                1'b1, 1, 1'b0, 1'b0); // LD out of range
    issue(1'b1, 3'b011, 64'd2041, 64'h55,              64'h0,                1'b1, 1, 1'b0, 1'b0); // SD out of range
    issue(1'b0, 3'b011, 64'h8000000000000000, 64'h0,   64'h0,                1'b1, 1, 1'b0, 1'b0); // no wrap
    issue(1'b0, 3'b111, 64'd0,  64'h0,                 64'h0,                1'b1, 1, 1'b0, 1'b0); // bad load f3
    issue(1'b1, 3'b100, 64'd0,  64'h0,                 64'h0,                1'b1, 1, 1'b0, 1'b0); // bad store f3

    // Reset while an SB sits in its read phase: the store must vanish.
    @(negedge clk);
    wc0        = wr_count;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 64'd40;
    req_wdata  = 64'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rmw_rd", 64'(mem_read), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 64'(wr_count - wc0), 64'd0);
    issue(1'b0, 3'b011, 64'd40, 64'h0,                 64'h0CC0A09088848281, 1'b0, 2, 1'b1, 1'b0); // unchanged

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
